// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, issues one outstanding request at a time to a variable-latency
// instruction memory, and feeds decode. It handles stalls via a one-entry hold
// buffer, redirects via a drain state, and stops fetching after a HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] Instr,
  output logic [15:0] PCplus2,
  output logic        valid,
  output logic        halt_fetched
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] drain_addr;   // address of the access being completed in DRAIN
  logic        req_en;       // suppresses the request in the cycle right after reset
  logic [15:0] instr_r;
  logic [15:0] pc2_r;
  logic        valid_r;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc2;
  logic        hold_vld;

  assign pc_inc       = pc + 16'd2;
  assign imem_req     = req_en & ((state == FETCH) | (state == DRAIN));
  assign imem_addr    = (state == DRAIN) ? drain_addr : pc;
  assign Instr        = valid_r ? instr_r : NOP_INSTR;
  assign PCplus2      = pc2_r;
  assign valid        = valid_r;
  assign halt_fetched = valid_r & (instr_r[15:11] == 5'b00000);

  // Fetch control, hold buffer and IF/ID register update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      req_en     <= 1'b0;
      instr_r    <= NOP_INSTR;
      pc2_r      <= 16'h0000;
      valid_r    <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc2   <= 16'h0000;
      hold_vld   <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (redirect) begin
        // Flush: bubble into IF/ID, drop any held instruction. An access
        // still in flight must complete at its old address before refetch.
        pc       <= redirect_pc;
        instr_r  <= NOP_INSTR;
        valid_r  <= 1'b0;
        hold_vld <= 1'b0;
        if (imem_req && !imem_done) begin
          state      <= DRAIN;
          drain_addr <= imem_addr;
        end else begin
          state <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            if (imem_req && imem_done) begin
              pc <= pc_inc;
              if (!stall) begin
                instr_r <= imem_data;
                pc2_r   <= pc_inc;
                valid_r <= 1'b1;
                state   <= (imem_data[15:11] == 5'b00000) ? HALT : FETCH;
              end else begin
                hold_instr <= imem_data;
                hold_pc2   <= pc_inc;
                hold_vld   <= 1'b1;
                state      <= HOLD;
              end
            end else if (!stall) begin
              instr_r <= NOP_INSTR;
              valid_r <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              instr_r  <= hold_instr;
              pc2_r    <= hold_pc2;
              valid_r  <= hold_vld;
              hold_vld <= 1'b0;
              state    <= (hold_vld && hold_instr[15:11] == 5'b00000) ? HALT : FETCH;
            end
          end
          HALT: begin
            if (!stall) begin
              instr_r <= NOP_INSTR;
              valid_r <= 1'b0;
            end
          end
          DRAIN: begin
            if (!stall) begin
              instr_r <= NOP_INSTR;
              valid_r <= 1'b0;
            end
            if (imem_done) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, latency, stall, redirect, halt,
// async reset mid-access and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_done = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] Instr;
  logic [15:0] PCplus2;
  logic        valid;
  logic        halt_fetched;

  int total = 0;
  int bad = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_done(imem_done),
    .imem_req(imem_req), .imem_addr(imem_addr), .Instr(Instr),
    .PCplus2(PCplus2), .valid(valid), .halt_fetched(halt_fetched)
  );

  always #5 clk = ~clk;

  // advance one clock edge, land 1ns after it
  task step;
    @(posedge clk); #1;
  endtask

  task do_reset;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_done = 1'b0;
    step(); step();
    rst = 1'b1;
    step();   // request should now be up at RESET_PC
  endtask

  task test_reset;
    rst = 1'b0;
    step();
    total++; if (Instr !== 16'h0800) begin bad++; $display("FAIL reset_instr got=%h exp=0800", Instr); end
    total++; if (PCplus2 !== 16'h0000) begin bad++; $display("FAIL reset_pc2 got=%h exp=0000", PCplus2); end
    total++; if ({valid, halt_fetched, imem_req} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {valid, halt_fetched, imem_req}); end
    rst = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task test_one_cycle;
    // continues from test_reset: request up at 0
    imem_done = 1'b1; imem_data = 16'h4101;
    step();
    total++; if (Instr !== 16'h4101 || PCplus2 !== 16'h0002 || valid !== 1'b1) begin bad++; $display("FAIL one_cyc_a got=%h/%h/%b exp=4101/0002/1", Instr, PCplus2, valid); end
    imem_data = 16'h4202;
    step();
    total++; if (Instr !== 16'h4202 || PCplus2 !== 16'h0004 || valid !== 1'b1) begin bad++; $display("FAIL one_cyc_b got=%h/%h/%b exp=4202/0004/1", Instr, PCplus2, valid); end
    total++; if (imem_addr !== 16'h0004) begin bad++; $display("FAIL one_cyc_addr got=%h exp=0004", imem_addr); end
    imem_done = 1'b0;
  endtask

  task test_latency;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL lat_addr_hold%0d got=%b/%h exp=1/0000", i, imem_req, imem_addr); end
      step();
      total++; if (Instr !== 16'h0800 || valid !== 1'b0) begin bad++; $display("FAIL lat_bubble%0d got=%h/%b exp=0800/0", i, Instr, valid); end
    end
    total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL lat_addr_3 got=%h exp=0000", imem_addr); end
    imem_done = 1'b1; imem_data = 16'h1234;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h1234 || valid !== 1'b1 || PCplus2 !== 16'h0002) begin bad++; $display("FAIL lat_data got=%h/%b/%h exp=1234/1/0002", Instr, valid, PCplus2); end
    total++; if (imem_addr !== 16'h0002 || imem_req !== 1'b1) begin bad++; $display("FAIL lat_next_addr got=%b/%h exp=1/0002", imem_req, imem_addr); end
  endtask

  task test_stall;
    // continues: Instr=1234, request at 2
    stall = 1'b1; imem_done = 1'b1; imem_data = 16'h5555;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h1234 || PCplus2 !== 16'h0002) begin bad++; $display("FAIL stall_hold got=%h/%h exp=1234/0002", Instr, PCplus2); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq got=%b exp=0", imem_req); end
    step();
    total++; if (Instr !== 16'h1234) begin bad++; $display("FAIL stall_hold2 got=%h exp=1234", Instr); end
    stall = 1'b0;
    step();
    total++; if (Instr !== 16'h5555 || PCplus2 !== 16'h0004 || valid !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%h/%b exp=5555/0004/1", Instr, PCplus2, valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin bad++; $display("FAIL stall_refetch got=%b/%h exp=1/0004", imem_req, imem_addr); end
    imem_done = 1'b1; imem_data = 16'h6666;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h6666 || PCplus2 !== 16'h0006) begin bad++; $display("FAIL stall_next got=%h/%h exp=6666/0006", Instr, PCplus2); end
  endtask

  task test_redirect;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL drain_old_addr got=%b/%h exp=1/0000", imem_req, imem_addr); end
    total++; if (Instr !== 16'h0800 || valid !== 1'b0) begin bad++; $display("FAIL drain_bubble got=%h/%b exp=0800/0", Instr, valid); end
    step();
    total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL drain_addr2 got=%h exp=0000", imem_addr); end
    imem_done = 1'b1; imem_data = 16'h7777;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h0800 || valid !== 1'b0) begin bad++; $display("FAIL drain_discard got=%h/%b exp=0800/0", Instr, valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin bad++; $display("FAIL drain_target got=%b/%h exp=1/0040", imem_req, imem_addr); end
    imem_done = 1'b1; imem_data = 16'h4A4A;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h4A4A || PCplus2 !== 16'h0042 || valid !== 1'b1) begin bad++; $display("FAIL drain_resume got=%h/%h/%b exp=4A4A/0042/1", Instr, PCplus2, valid); end
  endtask

  task test_halt;
    logic [15:0] prog [4];
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h0000;
    do_reset();
    imem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_data = prog[i];
      step();
    end
    imem_done = 1'b0;
    total++; if (halt_fetched !== 1'b1 || Instr !== 16'h0000 || PCplus2 !== 16'h0008) begin bad++; $display("FAIL halt_seen got=%b/%h/%h exp=1/0000/0008", halt_fetched, Instr, PCplus2); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_noreq got=%b exp=0", imem_req); end
    step();
    total++; if (halt_fetched !== 1'b0 || Instr !== 16'h0800 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_after got=%b/%h/%b exp=0/0800/0", halt_fetched, Instr, imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin bad++; $display("FAIL halt_resume_addr got=%b/%h exp=1/0010", imem_req, imem_addr); end
    imem_done = 1'b1; imem_data = 16'h1357;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h1357 || PCplus2 !== 16'h0012) begin bad++; $display("FAIL halt_resume_data got=%h/%h exp=1357/0012", Instr, PCplus2); end
  endtask

  task test_async_reset;
    do_reset();
    // redirect coinciding with done: no drain, straight to 0x20
    redirect = 1'b1; redirect_pc = 16'h0020; imem_done = 1'b1; imem_data = 16'h9999;
    step();
    redirect = 1'b0;
    imem_data = 16'h2468;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h2468 || PCplus2 !== 16'h0022 || imem_addr !== 16'h0022) begin bad++; $display("FAIL ar_setup got=%h/%h/%h exp=2468/0022/0022", Instr, PCplus2, imem_addr); end
    #1 rst = 1'b0;
    #1;
    total++; if (Instr !== 16'h0800 || PCplus2 !== 16'h0000 || valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL ar_immediate got=%h/%h/%b/%b exp=0800/0000/0/0", Instr, PCplus2, valid, imem_req); end
    step();
    rst = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL ar_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task test_wrap;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();   // in flight with done=0 -> drain
    redirect = 1'b0; imem_done = 1'b1;
    step();   // drain completes
    imem_data = 16'h4321;
    step();
    imem_done = 1'b0;
    total++; if (Instr !== 16'h4321 || PCplus2 !== 16'h0000 || imem_addr !== 16'h0000) begin bad++; $display("FAIL wrap got=%h/%h/%h exp=4321/0000/0000", Instr, PCplus2, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_one_cycle();
    test_latency();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
